// File: rtl/cpu_bus_pkg.sv
// Shared bus constants: widths, source count and the fixed source index map.
package cpu_bus_pkg;

  localparam int DATA_W = 32;
  localparam int NSRC   = 24;
  localparam int ENC_W  = 5;
  localparam int CNT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int SRC_R0     = 0;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

endpackage

// File: rtl/prio_enc_onehot.sv
// Priority encoder: lowest asserted request wins; also flags any/multiple requests.
module prio_enc_onehot
  import cpu_bus_pkg::*;
#(
  parameter int N     = NSRC,
  parameter int IDX_W = ENC_W
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  always_comb begin
    // NOTE: every output gets a default first so this block can never infer a latch.
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o   = |req_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(req_i & (req_i - N'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered bus multiplexer with keeper and optional contention monitor.
// Contention detection is built only when BUS_CONTENTION_CHK_EN is defined.
module bus_mux_reg
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W = cpu_bus_pkg::DATA_W,
  parameter int NSRC   = cpu_bus_pkg::NSRC
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [NSRC-1:0]        src_sel,
  input  logic                   clr_err,
  output logic [DATA_W-1:0]      bus_mux_out,
  output logic [ENC_W-1:0]       enc_code,
  output logic                   bus_valid,
  output logic                   contention,
  output logic [CNT_W-1:0]       contention_cnt
);

  logic [ENC_W-1:0]  sel_idx;
  logic              sel_any;
  logic              sel_multi;

  logic [DATA_W-1:0] bus_q, bus_d;
  logic [ENC_W-1:0]  enc_q, enc_d;
  logic              valid_q, valid_d;

  prio_enc_onehot #(
    .N     (NSRC),
    .IDX_W (ENC_W)
  ) u_prio_enc (
    .req_i   (src_sel),
    .idx_o   (sel_idx),
    .any_o   (sel_any),
    .multi_o (sel_multi)
  );

  // With no source enabled the previous word is kept.
  always_comb begin
    bus_d   = bus_q;
    enc_d   = enc_q;
    valid_d = sel_any;
    if (sel_any) begin
      bus_d = src_data[int'(sel_idx)*DATA_W +: DATA_W];
      enc_d = sel_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_q   <= '0;
      enc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
    end
  end

  assign bus_mux_out = bus_q;
  assign enc_code    = enc_q;
  assign bus_valid   = valid_q;

`ifdef BUS_CONTENTION_CHK_EN
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear on the same edge as a contention wins over it.
  always_comb begin
    cont_d = cont_q;
    cnt_d  = cnt_q;
    if (clr_err) begin
      cont_d = 1'b0;
      cnt_d  = '0;
    end else if (sel_multi) begin
      cont_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cont_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cont_q <= cont_d;
      cnt_q  <= cnt_d;
    end
  end

  assign contention     = cont_q;
  assign contention_cnt = cnt_q;
`else
  logic unused_contention_inputs;
  assign unused_contention_inputs = ^{clr_err, sel_multi};

  assign contention     = 1'b0;
  assign contention_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed self-checking bench for bus_mux_reg; expectations follow BUS_CONTENTION_CHK_EN.
module tb_bus_mux_reg;

  localparam int DW = 32;
  localparam int NS = 24;

`ifdef BUS_CONTENTION_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk;
  logic             clr;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_sel;
  logic             clr_err;
  logic [DW-1:0]    bus_mux_out;
  logic [4:0]       enc_code;
  logic             bus_valid;
  logic             contention;
  logic [7:0]       contention_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bus_mux_reg #(
    .DATA_W (DW),
    .NSRC   (NS)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .src_data       (src_data),
    .src_sel        (src_sel),
    .clr_err        (clr_err),
    .bus_mux_out    (bus_mux_out),
    .enc_code       (enc_code),
    .bus_valid      (bus_valid),
    .contention     (contention),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    src_data[idx*DW +: DW] = val;
  endtask

  task automatic check_all(input string tag, input logic [31:0] bus, input logic [4:0] enc,
                           input logic vld, input logic cont, input logic [7:0] cnt);
    check({tag, ".bus"},   bus_mux_out,    bus);
    check({tag, ".enc"},   enc_code,       enc);
    check({tag, ".valid"}, bus_valid,      vld);
    check({tag, ".cont"},  contention,     cont);
    check({tag, ".cnt"},   contention_cnt, cnt);
  endtask

  initial begin
    clr      = 1'b1;
    clr_err  = 1'b0;
    src_sel  = '0;
    src_data = '0;
    for (int i = 0; i < NS; i++) set_word(i, 32'h0100_0000 + i);
    set_word(0,  32'hDEAD_BEEF);
    set_word(3,  32'hAAAA_5555);
    set_word(17, 32'h5555_AAAA);
    set_word(20, 32'h0000_0040);
    set_word(21, 32'h0BAD_F00D);
    set_word(23, 32'h1234_5678);

    #3;
    check_all("reset", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);
    step();
    clr = 1'b0;

    // First edge after release with nothing selected: no spurious valid.
    step();
    check_all("post_reset_idle", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);

    // Single source PC.
    src_sel = 24'(1) << 20;
    step();
    check_all("pc", 32'h0000_0040, 5'd20, 1'b1, 1'b0, 8'd0);

    // Idle hold for three cycles.
    src_sel = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_all($sformatf("idle%0d", c), 32'h0000_0040, 5'd20, 1'b0, 1'b0, 8'd0);
    end

    // Highest index source and index 0 passed through unmodified.
    src_sel = 24'(1) << 23;
    step();
    check_all("csign", 32'h1234_5678, 5'd23, 1'b1, 1'b0, 8'd0);
    src_sel = 24'h00_0001;
    step();
    check_all("r0", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 8'd0);

    // Contention between R3 and LO: lowest index wins.
    src_sel = (24'(1) << 3) | (24'(1) << 17);
    step();
    check_all("contend", 32'hAAAA_5555, 5'd3, 1'b1, CHK_EN, CHK_EN ? 8'd1 : 8'd0);

    // 300 contention cycles in total saturate the counter.
    for (int c = 1; c < 300; c++) step();
    check_all("saturate", 32'hAAAA_5555, 5'd3, 1'b1, CHK_EN, CHK_EN ? 8'd255 : 8'd0);

    // Clear on the same edge as a contention wins.
    clr_err = 1'b1;
    step();
    check_all("clr_err", 32'hAAAA_5555, 5'd3, 1'b1, 1'b0, 8'd0);
    clr_err = 1'b0;

    // Single driver after clear leaves the flag clear; next contention counts from 1.
    src_sel = 24'(1) << 17;
    step();
    check_all("lo_single", 32'h5555_AAAA, 5'd17, 1'b1, 1'b0, 8'd0);
    src_sel = (24'(1) << 3) | (24'(1) << 21);
    step();
    check_all("recount", 32'hAAAA_5555, 5'd3, 1'b1, CHK_EN, CHK_EN ? 8'd1 : 8'd0);

    // Asynchronous reset pulse between edges with MDR selected.
    src_sel = 24'(1) << 21;
    #2;
    clr = 1'b1;
    #1;
    check_all("async_clr", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);
    clr = 1'b0;
    step();
    check_all("after_clr", 32'h0BAD_F00D, 5'd21, 1'b1, 1'b0, 8'd0);

    // Reset held across an edge discards the pending capture.
    src_sel = 24'(1) << 20;
    clr = 1'b1;
    step();
    check_all("clr_held", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);
    src_sel = '0;
    clr = 1'b0;
    step();
    check_all("clr_release_idle", 32'h0, 5'd0, 1'b0, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mux_reg.md
BUS_MUX_REG -- requirements
Module: bus_mux_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus/data width in bits.
REQ-002 SHALL have parameter NSRC, default 24, number of bus sources: R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C_sign_extended, in index order 0..23.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port clr  input  1  asynchronous active-high reset.
REQ-005 SHALL have port src_data  input  NSRC*DATA_W  packed source words; source i occupies bits [i*DATA_W +: DATA_W] (e.g. BusMuxIn_R0 at index 0).
REQ-006 SHALL have port src_sel  input  NSRC  per-source out-enables (R0out..Cout).
REQ-007 SHALL have port clr_err  input  1  synchronous clear of contention status.
REQ-008 SHALL have port bus_mux_out  output  DATA_W  registered bus value.
REQ-009 SHALL have port enc_code  output  5  registered index of the winning source.
REQ-010 SHALL have port bus_valid  output  1  high one cycle after any src_sel bit was asserted.
REQ-011 SHALL have port contention  output  1  sticky multiple-driver flag.
REQ-012 SHALL have port contention_cnt  output  8  saturating count of multiple-driver cycles.

Function
REQ-013 SHALL encode src_sel combinationally to the lowest asserted index; the winner's word SHALL be captured into bus_mux_out on the next rising clk (latency 1 cycle).
REQ-014 SHALL capture the same winning index into enc_code on that same edge.
REQ-015 SHALL drive bus_valid high for exactly the cycle after each edge that sampled at least one src_sel bit set.
REQ-016 SHALL hold bus_mux_out and enc_code unchanged (bus keeper) and drive bus_valid low when src_sel is all zero.
REQ-017 SHALL, on an edge sampling two or more src_sel bits set, still capture the lowest-index source, set contention, and increment contention_cnt.
REQ-018 SHALL saturate contention_cnt at 255; no wrap to 0.
REQ-019 SHALL, when clr_err is high at an edge, clear contention and contention_cnt to 0; if contention occurs on that same edge, clr_err wins and both read 0.
REQ-020 SHALL treat src_sel bits at index >= NSRC as nonexistent; enc_code SHALL never exceed NSRC-1.
REQ-021 SHALL pass source data unmodified; R0 zeroing under BAout is done upstream, and this block SHALL NOT special-case index 0.

Reset
REQ-022 SHALL, while clr is high, asynchronously force bus_mux_out=0, enc_code=0, bus_valid=0, contention=0 and contention_cnt=0.
REQ-023 SHALL, on clr deassertion, resume normal operation at the first rising clk with no lost or spurious bus_valid.
REQ-024 SHALL, on clr asserted mid-transfer, discard the pending capture; nothing from before reset SHALL appear after it.

Configuration
REQ-025 SHALL compile contention detection in only when macro BUS_CONTENTION_CHK_EN is defined.
REQ-026 SHALL, with BUS_CONTENTION_CHK_EN undefined, tie contention and contention_cnt to 0, ignore clr_err, and leave REQ-013 to REQ-016 unchanged.

Structure
REQ-027 SHALL take DATA_W, NSRC and the source-index constants (SRC_R0..SRC_CSIGN) from the shared package cpu_bus_pkg.
REQ-028 SHALL implement the priority encoder as sub-module prio_enc_onehot (NSRC-bit one-hot in; index, any and multi flags out).

Verification
REQ-029 SHALL verify single source: src_sel=1<<20 (PC), PC word=0x0000_0040 -> next edge bus_mux_out=0x40, enc_code=20, bus_valid=1.
REQ-030 SHALL verify idle hold: after REQ-029, src_sel=0 for 3 cycles -> bus_mux_out stays 0x40, bus_valid=0.
REQ-031 SHALL verify contention: src_sel with bits 3 and 17 set, R3=0xAAAA_5555 -> bus_mux_out=0xAAAA_5555, enc_code=3, contention=1, contention_cnt=1.
REQ-032 SHALL verify saturation and clear: 300 contention cycles -> contention_cnt=255; then clr_err together with contention -> contention=0, contention_cnt=0.
REQ-033 SHALL verify async reset: clr pulsed between clock edges with src_sel active -> all outputs 0 immediately; first edge after release captures the new source.
REQ-034 SHALL verify macro off: REQ-031 stimulus with BUS_CONTENTION_CHK_EN undefined -> contention=0, contention_cnt=0, data as REQ-031.
